adder4_bist_checker: RTL and testbench

Synthesizable built-in self-test engine for the 4-bit ripple adder. It drives A/B/Cin into the adder and samples Sum/Cout back from it. It walks all 2^(2*WIDTH+1) input combinations, compares each result against an internally computed golden sum, and counts mismatches. It also captures the first failing vector. It sits beside the adder in silicon/FPGA, so the exhaustive check the simulation bench does by hand runs on-chip from a single start pulse.

---
 rtl/adder4_bist_checker.sv | 151 +++++++++++++++
 tb/tb_adder4_bist_checker.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder4_bist_checker.sv
// adder4_bist_checker
// On-chip exhaustive self-test for a WIDTH-bit ripple adder.
// - Walks every {Cin,B,A} combination through the adder.
// - Compares each result against an internally computed golden sum.
// - Counts mismatches in a saturating counter and captures the first failing vector.
// Build option: define ADDER4_BIST_STOP_ON_FAIL_EN to end the run at the first mismatch.
module adder4_bist_checker #(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_CNT_W     = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [WIDTH-1:0]     dut_A,
   output logic [WIDTH-1:0]     dut_B,
   output logic                 dut_Cin,
   input  logic [WIDTH-1:0]     dut_Sum,
   input  logic                 dut_Cout,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [2*WIDTH:0]     fail_vec,
   output logic [WIDTH:0]       fail_obs
);

   localparam int IDX_W = 2*WIDTH + 1;
   localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t             state;
   state_t             next_state;
   logic [IDX_W-1:0]   idx;
   logic [CNT_W-1:0]   settle_cnt;
   logic               first_seen;   // set once the first failure has been captured
   logic [WIDTH:0]     golden;
   logic [WIDTH:0]     observed;
   logic               mismatch;
   logic               last_idx;
   logic               start_run;
   logic               stop_run;

   // Golden result and comparison against the adder outputs (valid in CHECK)
   assign golden   = {1'b0, dut_A} + {1'b0, dut_B} + {{WIDTH{1'b0}}, dut_Cin};
   assign observed = {dut_Cout, dut_Sum};
   assign mismatch = (golden != observed);
   assign last_idx = (idx == {IDX_W{1'b1}});

   // A start pulse is honoured only from the resting states
   assign start_run = start && ((state == S_IDLE) || (state == S_DONE));

`ifdef ADDER4_BIST_STOP_ON_FAIL_EN
   assign stop_run = last_idx || mismatch;
`else
   assign stop_run = last_idx;
`endif

   // State register
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode
   // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE, S_DONE: if (start) next_state = S_APPLY;
         S_APPLY:        next_state = S_SETTLE;
         S_SETTLE:       if (settle_cnt == CNT_W'(1)) next_state = S_CHECK;
         S_CHECK:        next_state = stop_run ? S_DONE : S_APPLY;
         default:        next_state = S_IDLE;
      endcase
   end

   // Status outputs decoded from the state
   always_comb begin
      busy = (state == S_APPLY) || (state == S_SETTLE) || (state == S_CHECK);
      done = (state == S_DONE);
      pass = done && (err_count == '0);
   end

   // Vector walk: operands, settle timer, index advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         settle_cnt <= '0;
         dut_A      <= '0;
         dut_B      <= '0;
         dut_Cin    <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start_run) idx <= '0;
            end
            S_APPLY: begin
               dut_A      <= idx[WIDTH-1:0];
               dut_B      <= idx[2*WIDTH-1:WIDTH];
               dut_Cin    <= idx[2*WIDTH];
               settle_cnt <= CNT_W'(SETTLE_CYCLES);
            end
            S_SETTLE: begin
               settle_cnt <= settle_cnt - CNT_W'(1);
            end
            S_CHECK: begin
               if (!stop_run) idx <= idx + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Error accounting: saturating counter and first-failure capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count  <= '0;
         fail_vec   <= '0;
         fail_obs   <= '0;
         first_seen <= 1'b0;
      end else if (start_run) begin
         err_count  <= '0;
         fail_vec   <= '0;
         fail_obs   <= '0;
         first_seen <= 1'b0;
      end else if ((state == S_CHECK) && mismatch) begin
         if (err_count != {ERR_CNT_W{1'b1}}) begin
            err_count <= err_count + ERR_CNT_W'(1);
         end
         // A separate flag, not err_count, arms capture so saturation cannot re-trigger it
         if (!first_seen) begin
            fail_vec   <= {dut_Cin, dut_B, dut_A};
            fail_obs   <= observed;
            first_seen <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_adder4_bist_checker.sv
// tb_adder4_bist_checker
// Directed bench for adder4_bist_checker.
// - Two instances share the bench: a default one, and one built with ERR_CNT_W=8 for saturation.
// - Each instance drives a behavioural adder that can have a fault planted in it.
module tb_adder4_bist_checker;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       start8;
   int         fault;
   int         fault8;
   int         tests_run;
   int         tests_failed;

   logic [3:0] dut_a, dut_b, dut_sum;
   logic       dut_cin, dut_cout;
   logic       busy, done, pass;
   logic [9:0] err_count;
   logic [8:0] fail_vec;
   logic [4:0] fail_obs;

   logic [3:0] dut_a8, dut_b8, dut_sum8;
   logic       dut_cin8, dut_cout8;
   logic       busy8, done8, pass8;
   logic [7:0] err_count8;
   logic [8:0] fail_vec8;
   logic [4:0] fail_obs8;

   // Fault modes: 0 = correct adder, 1 = Cout stuck at 0, 2 = Sum[0] inverted
   function automatic logic [4:0] adder_model(input logic [3:0] a, input logic [3:0] b,
                                              input logic cin, input int mode);
      logic [4:0] r;
      r = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      if (mode == 1) r[4] = 1'b0;
      if (mode == 2) r[0] = ~r[0];
      return r;
   endfunction

   assign {dut_cout, dut_sum}   = adder_model(dut_a, dut_b, dut_cin, fault);
   assign {dut_cout8, dut_sum8} = adder_model(dut_a8, dut_b8, dut_cin8, fault8);

   adder4_bist_checker u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dut_A     (dut_a),
      .dut_B     (dut_b),
      .dut_Cin   (dut_cin),
      .dut_Sum   (dut_sum),
      .dut_Cout  (dut_cout),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_vec  (fail_vec),
      .fail_obs  (fail_obs)
   );

   adder4_bist_checker #(.ERR_CNT_W(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start8),
      .dut_A     (dut_a8),
      .dut_B     (dut_b8),
      .dut_Cin   (dut_cin8),
      .dut_Sum   (dut_sum8),
      .dut_Cout  (dut_cout8),
      .busy      (busy8),
      .done      (done8),
      .pass      (pass8),
      .err_count (err_count8),
      .fail_vec  (fail_vec8),
      .fail_obs  (fail_obs8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle start pulse; returns #1 after the edge that samples it
   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   // Counts edges after the start-sampling edge until done; start re-pulsed once at inject_at
   task automatic wait_done(input int inject_at, output int cycles);
      cycles = 0;
      while (cycles < 5000) begin
         @(posedge clk); #1;
         cycles++;
         start = (cycles == inject_at);
         if (done) break;
      end
      start = 1'b0;
      if (!done) begin
         tests_run++; tests_failed++;
         $display("FAIL wait_done timeout: done=%0b after %0d cycles, required 1", done, cycles);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; start8 = 1'b0; fault = 0; fault8 = 0;
      #12;
      tests_run++;
      if ({busy, done, pass, err_count, fail_vec, fail_obs, dut_a, dut_b, dut_cin} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got busy=%0b done=%0b pass=%0b err=%0d vec=%0h obs=%0h a=%0h b=%0h cin=%0b, required all 0",
                  busy, done, pass, err_count, fail_vec, fail_obs, dut_a, dut_b, dut_cin);
      end
      tests_run++;
      if ({busy8, done8, pass8, err_count8} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs8: got busy=%0b done=%0b pass=%0b err=%0d, required all 0",
                  busy8, done8, pass8, err_count8);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_correct_adder();
      int cycles;
      fault = 0;
      pulse_start();
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++; $display("FAIL correct_busy_rise: got %0b, required 1", busy);
      end
      wait_done(-1, cycles);
      tests_run++;
      if (cycles !== 2048) begin
         tests_failed++; $display("FAIL correct_run_len: got %0d cycles, required 2048", cycles);
      end
      tests_run++;
      if ({busy, done, pass} !== 3'b011) begin
         tests_failed++; $display("FAIL correct_flags: got busy/done/pass=%b, required 011", {busy, done, pass});
      end
      tests_run++;
      if ({err_count, fail_vec, fail_obs} !== '0) begin
         tests_failed++;
         $display("FAIL correct_results: got err=%0d vec=%0h obs=%0h, required 0 0 0", err_count, fail_vec, fail_obs);
      end
      // Operands hold the last vector {1,F,F}
      tests_run++;
      if ({dut_cin, dut_b, dut_a} !== 9'h1FF) begin
         tests_failed++; $display("FAIL hold_last_vec: got %0h, required 1ff", {dut_cin, dut_b, dut_a});
      end
   endtask

   task automatic test_cout_stuck();
      int cycles;
      fault = 1;
      pulse_start();
      wait_done(-1, cycles);
`ifdef ADDER4_BIST_STOP_ON_FAIL_EN
      tests_run++;
      if (cycles !== 128) begin
         tests_failed++; $display("FAIL stuck_run_len: got %0d cycles, required 128", cycles);
      end
      tests_run++;
      if (err_count !== 10'd1) begin
         tests_failed++; $display("FAIL stuck_err_count: got %0d, required 1", err_count);
      end
`else
      tests_run++;
      if (cycles !== 2048) begin
         tests_failed++; $display("FAIL stuck_run_len: got %0d cycles, required 2048", cycles);
      end
      tests_run++;
      if (err_count !== 10'd256) begin
         tests_failed++; $display("FAIL stuck_err_count: got %0d, required 256", err_count);
      end
`endif
      tests_run++;
      if (fail_vec !== 9'd31) begin
         tests_failed++; $display("FAIL stuck_fail_vec: got %0d, required 31", fail_vec);
      end
      tests_run++;
      if (fail_obs !== 5'd0) begin
         tests_failed++; $display("FAIL stuck_fail_obs: got %0h, required 0", fail_obs);
      end
      tests_run++;
      if ({done, pass} !== 2'b10) begin
         tests_failed++; $display("FAIL stuck_done_pass: got %b, required 10", {done, pass});
      end
   endtask

   task automatic test_sum0_saturate();
      int cycles;
      fault8 = 2;
      @(posedge clk); #1 start8 = 1'b1;
      @(posedge clk); #1 start8 = 1'b0;
      cycles = 0;
      while (!done8 && cycles < 5000) begin
         @(posedge clk); #1;
         cycles++;
      end
      tests_run++;
      if (done8 !== 1'b1) begin
         tests_failed++; $display("FAIL sat_timeout: done=%0b after %0d cycles, required 1", done8, cycles);
      end
`ifdef ADDER4_BIST_STOP_ON_FAIL_EN
      tests_run++;
      if (err_count8 !== 8'd1) begin
         tests_failed++; $display("FAIL sat_err_count: got %0d, required 1", err_count8);
      end
`else
      tests_run++;
      if (err_count8 !== 8'd255) begin
         tests_failed++; $display("FAIL sat_err_count: got %0d, required 255", err_count8);
      end
`endif
      tests_run++;
      if (fail_vec8 !== 9'd0) begin
         tests_failed++; $display("FAIL sat_fail_vec: got %0h, required 0", fail_vec8);
      end
      tests_run++;
      if (fail_obs8 !== 5'b00001) begin
         tests_failed++; $display("FAIL sat_fail_obs: got %b, required 00001", fail_obs8);
      end
      tests_run++;
      if (pass8 !== 1'b0) begin
         tests_failed++; $display("FAIL sat_pass: got %0b, required 0", pass8);
      end
   endtask

   task automatic test_reset_midrun();
      int cycles;
      fault = 1;
      pulse_start();
      repeat (700) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({busy, done, pass, err_count, fail_vec, fail_obs, dut_a, dut_b, dut_cin} !== '0) begin
         tests_failed++;
         $display("FAIL midrun_reset: got busy=%0b done=%0b pass=%0b err=%0d vec=%0h obs=%0h a=%0h b=%0h cin=%0b, required all 0",
                  busy, done, pass, err_count, fail_vec, fail_obs, dut_a, dut_b, dut_cin);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if ({busy, done} !== 2'b00) begin
         tests_failed++; $display("FAIL midrun_idle: got busy/done=%b, required 00", {busy, done});
      end
      fault = 0;
      pulse_start();
      wait_done(-1, cycles);
      tests_run++;
      if ({pass, err_count} !== {1'b1, 10'd0} || cycles !== 2048) begin
         tests_failed++;
         $display("FAIL midrun_rerun: got pass=%0b err=%0d cycles=%0d, required 1 0 2048", pass, err_count, cycles);
      end
   endtask

   task automatic test_start_ignored();
      int cycles;
      // Faulty run so DONE holds a nonzero count; start re-pulsed at cycle 100 and in the final CHECK
      fault = 1;
      pulse_start();
`ifdef ADDER4_BIST_STOP_ON_FAIL_EN
      wait_done(100, cycles);
      tests_run++;
      if (cycles !== 128) begin
         tests_failed++; $display("FAIL busy_restart_len: got %0d cycles, required 128", cycles);
      end
`else
      wait_done(100, cycles);
      tests_run++;
      if (cycles !== 2048) begin
         tests_failed++; $display("FAIL busy_restart_len: got %0d cycles, required 2048", cycles);
      end
      // Fault-free run with start asserted during the last CHECK
      fault = 0;
      pulse_start();
      wait_done(2047, cycles);
      @(posedge clk); #1;
      tests_run++;
      if ({done, busy, pass} !== 3'b101 || cycles !== 2048) begin
         tests_failed++;
         $display("FAIL last_check_start: got done/busy/pass=%b cycles=%0d, required 101 2048", {done, busy, pass}, cycles);
      end
      fault = 1;
      pulse_start();
      wait_done(-1, cycles);
`endif
      // Start in DONE: done drops, a fresh run begins with a cleared count
      fault = 0;
      pulse_start();
      tests_run++;
      if ({done, busy, err_count} !== {1'b0, 1'b1, 10'd0}) begin
         tests_failed++;
         $display("FAIL done_restart: got done=%0b busy=%0b err=%0d, required 0 1 0", done, busy, err_count);
      end
      wait_done(-1, cycles);
      tests_run++;
      if (pass !== 1'b1) begin
         tests_failed++; $display("FAIL done_restart_pass: got %0b, required 1", pass);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_correct_adder();
      test_cout_stuck();
      test_sum0_saturate();
      test_reset_midrun();
      test_start_ignored();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
